matrix_3x3_gen: RTL and testbench



---
 rtl/img_pkg.sv | 7 +
 rtl/line_buffer.sv | 16 +
 rtl/matrix_3x3_gen.sv | 54 +++++
 tb/tb_matrix_3x3_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared image geometry and pixel type
package img_pkg;
  localparam int DW = 10;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  typedef logic [DW-1:0] pixel_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of storage, read-before-write at a shared address
module line_buffer import img_pkg::*; #(
  parameter int DW = img_pkg::DW,
  parameter int DEPTH = img_pkg::IMG_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  assign rd = mem[addr];
  always_ff @(posedge clk) if (we) mem[addr] <= wd;
endmodule

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: streaming 3x3 neighbourhood window over two buffered lines
module matrix_3x3_gen import img_pkg::*; #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int IMG_H = img_pkg::IMG_H,
  parameter int DW = img_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          ien,
  input  logic [DW-1:0] din,
  output logic          oen,
  output logic [DW-1:0] data11,
  output logic [DW-1:0] data12,
  output logic [DW-1:0] data13,
  output logic [DW-1:0] data21,
  output logic [DW-1:0] data22,
  output logic [DW-1:0] data23,
  output logic [DW-1:0] data31,
  output logic [DW-1:0] data32,
  output logic [DW-1:0] data33
);
  localparam int cw = $clog2(IMG_W);
  localparam int rw = $clog2(IMG_H);
  localparam logic [cw-1:0] col_max = cw'(IMG_W - 1);
  localparam logic [rw-1:0] row_max = rw'(IMG_H - 1);
  logic [cw-1:0] col, c_col;
  logic [rw-1:0] row, c_row;
  logic [DW-1:0] l1, l2;
  // frame_start retargets the pixel presented with it to (0,0)
  assign c_col = frame_start ? '0 : col;
  assign c_row = frame_start ? '0 : row;
  line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line1 (.clk, .we(ien), .addr(c_col), .wd(din), .rd(l1));
  line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line2 (.clk, .we(ien), .addr(c_col), .wd(l1), .rd(l2));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      oen <= 1'b0;
      {data11, data12, data13, data21, data22, data23, data31, data32, data33} <= '0;
    end else begin
      oen <= ien && c_row >= rw'(2) && c_col >= cw'(2);
      if (ien) begin
        col <= c_col == col_max ? '0 : c_col + cw'(1);
        row <= c_col != col_max ? c_row : c_row == row_max ? '0 : c_row + rw'(1);
        {data11, data12, data13} <= {data12, data13, l2};
        {data21, data22, data23} <= {data22, data23, l1};
        {data31, data32, data33} <= {data32, data33, din};
      end else if (frame_start) begin
        col <= '0;
        row <= '0;
      end
    end
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: directed streams checked against a pixel-grid model of the window
module tb_matrix_3x3_gen;
  localparam int W = 8, H = 4, DW = 10;
  typedef logic [9*DW-1:0] win_t;
  logic clk = 0, rst_n = 0, frame_start = 0, ien = 0;
  logic [DW-1:0] din = 0;
  logic oen;
  logic [DW-1:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
  win_t dut_win, exp_win, ref_w[$], wins[$];
  logic exp_oen = 0;
  bit hold_valid = 0, chk_en = 0;
  int compared = 0, mismatched = 0;
  int mrow = 0, mcol = 0, acc_cnt = 0, first_idx = -1;
  int pix [H][W];

  always #5 clk = ~clk;

  matrix_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .ien(ien), .din(din), .oen(oen),
    .data11(data11), .data12(data12), .data13(data13),
    .data21(data21), .data22(data22), .data23(data23),
    .data31(data31), .data32(data32), .data33(data33));

  assign dut_win = {data11, data12, data13, data21, data22, data23, data31, data32, data33};

  task automatic check(input string name, input win_t act, input win_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mrow = 0; mcol = 0; exp_oen = 0; exp_win = '0; hold_valid = 1;
  endtask

  // pixel grid model: the window is simply the 3x3 block of the image ending at the accepted pixel
  task automatic send(input bit fs, input bit en, input int v);
    int r, c;
    frame_start = fs; ien = en; din = v[DW-1:0];
    @(posedge clk);
    if (fs) begin mrow = 0; mcol = 0; end
    if (en) begin
      r = mrow; c = mcol;
      pix[r][c] = v;
      acc_cnt++;
      exp_oen = r >= 2 && c >= 2;
      hold_valid = exp_oen;
      if (exp_oen)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(8 - (i*3 + j))*DW +: DW] = DW'(pix[r-2+i][c-2+j]);
      mcol++;
      if (mcol == W) begin mcol = 0; mrow = (mrow + 1) % H; end
    end else exp_oen = 0;
    #1 frame_start = 0; ien = 0;
  endtask

  task automatic px(input int k, input bit fs);
    send(fs, 1, ((k / W) % H) * 16 + k % W);
  endtask

  always @(negedge clk) if (rst_n && chk_en) begin
    check("oen", win_t'(oen), win_t'(exp_oen));
    if (exp_oen || hold_valid) check("window", dut_win, exp_win);
    if (oen) begin
      wins.push_back(dut_win);
      if (first_idx < 0) first_idx = acc_cnt - 1;
    end
  end

  initial begin
    model_reset();
    #12 rst_n = 1;
    @(posedge clk); #1 chk_en = 1;
    for (int k = 0; k < 22; k++) px(k, 0);
    #2 rst_n = 0;
    #1 check("rst_oen", win_t'(oen), 0);
    check("rst_data", dut_win, 0);
    model_reset();
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    wins.delete(); acc_cnt = 0; first_idx = -1;
    for (int k = 0; k < W*H; k++) px(k, 0);
    send(0, 0, 0); send(0, 0, 0);
    check("first_oen_idx", win_t'(first_idx), 18);
    check("oen_count", win_t'(wins.size()), 12);
    if (wins.size() >= 7) begin
      check("first_d11", win_t'(wins[0][8*DW +: DW]), 'h00);
      check("first_d13", win_t'(wins[0][6*DW +: DW]), 'h02);
      check("first_d22", win_t'(wins[0][4*DW +: DW]), 'h11);
      check("first_d33", win_t'(wins[0][0 +: DW]), 'h22);
      check("wrap_d11", win_t'(wins[6][8*DW +: DW]), 'h10);
      check("wrap_d33", win_t'(wins[6][0 +: DW]), 'h32);
    end
    ref_w = wins;
    wins.delete();
    for (int k = 0; k < W*H; k++) begin
      for (int g = $urandom_range(0, 5); g > 0; g--) send(0, 0, 0);
      px(k, 0);
    end
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    check("gap_count", win_t'(wins.size()), 12);
    for (int i = 0; i < 12 && i < wins.size() && i < ref_w.size(); i++) check("gap_win", wins[i], ref_w[i]);
    wins.delete();
    for (int k = 0; k < 2*W + 5; k++) px(k, 0);
    send(0, 0, 0);
    check("pre_restart_count", win_t'(wins.size()), 3);
    wins.delete();
    px(0, 1);
    for (int k = 1; k < W*H; k++) px(k, 0);
    send(0, 0, 0); send(0, 0, 0);
    check("restart_count", win_t'(wins.size()), 12);
    for (int i = 0; i < 12 && i < wins.size() && i < ref_w.size(); i++) check("restart_win", wins[i], ref_w[i]);
    wins.delete();
    for (int k = 0; k < 2*W*H; k++) px(k, 0);
    send(0, 0, 0); send(0, 0, 0);
    check("b2b_count", win_t'(wins.size()), 24);
    for (int i = 0; i < 12 && i + 12 < wins.size() && i < ref_w.size(); i++) begin
      check("b2b_f1", wins[i], ref_w[i]);
      check("b2b_f2", wins[i+12], ref_w[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
